// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CTRL_ADD = 1'b0;
    localparam logic CTRL_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full-adder / full-subtractor cell shared over time by serial_addsub.
module serial_fa_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic ctrl,
    output logic s,
    output logic c_out
);

    // Sum/difference bit is the same XOR; only the carry/borrow term differs.
    always_comb begin
        s = a ^ b ^ c;
        if (ctrl == CTRL_SUB) begin
            c_out = (~a & b) | (~a & c) | (b & c);
        end else begin
            c_out = (a & b) | (c & (a ^ b));
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: latches operands on start, processes one bit per
// clock LSB first, and presents the result with a one-cycle done pulse.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ctrl,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] res;
    logic           op;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           fa_s;
    logic           fa_c;

    serial_fa_cell u_cell (
        .a     (sha[0]),
        .b     (shb[0]),
        .c     (carry),
        .ctrl  (op),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, carry, counter and result registers.
    // s/cout are loaded on the edge that enters DONE so the new result is
    // visible in the same cycle as the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha   <= '0;
            shb   <= '0;
            res   <= '0;
            op    <= CTRL_ADD;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sha   <= a;
                        shb   <= b;
                        op    <= ctrl;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sha   <= sha >> 1;
                    shb   <= shb >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        s    <= {fa_s, res[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
